// File: rtl/intrapred_pkg.sv
// Shared types and constants for the intra-prediction frame sequencer.
package intrapred_pkg;

    localparam int unsigned INTRAPRED_PIPE_DEPTH      = 5;
    localparam int unsigned INTRAPRED_MB_NUMBER_BITS  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef logic [INTRAPRED_MB_NUMBER_BITS:0] mb_num_t;

endpackage

// File: rtl/intrapred_tag_pipe.sv
// Valid/tag shift register mirroring the macroblock held by each pipeline stage.
module intrapred_tag_pipe #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned TAG_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic [DEPTH-1:0] valid,
    output logic [TAG_W-1:0] last_tag
);

    logic [DEPTH-1:0][TAG_W-1:0] tag_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            tag_q <= '0;
        end else if (flush) begin
            valid <= '0;
            tag_q <= '0;
        end else if (advance) begin
            valid <= {valid[DEPTH-2:0], in_valid};
            tag_q <= {tag_q[DEPTH-2:0], in_tag};
        end
    end

    assign last_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/intrapred_mb_scheduler.sv
// Frame sequencer: issues macroblock numbers into the intra-prediction pipeline,
// tracks stage occupancy and hands finished macroblocks downstream via valid/ready.
module intrapred_mb_scheduler
    import intrapred_pkg::*;
#(
    parameter int unsigned MB_NUMBER_BITS = INTRAPRED_MB_NUMBER_BITS,
    parameter int unsigned NUM_MBS        = 396,
    parameter int unsigned PIPE_DEPTH     = INTRAPRED_PIPE_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic                    advance,
    output logic [MB_NUMBER_BITS:0] mbnumber,
    output logic [PIPE_DEPTH-1:0]   stage_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MB_NUMBER_BITS:0] out_mbnumber,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int unsigned     CNT_W   = MB_NUMBER_BITS + 2;
    localparam logic [CNT_W-1:0] LAST_MB = CNT_W'(NUM_MBS - 1);

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  retire_cnt;
    logic              in_run;
    logic              issue;
    logic              transfer;
    logic              flush;

    assign in_run     = (state_q == RUN);
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign frame_done = (state_q == DONE);
    assign out_valid  = stage_valid[PIPE_DEPTH-1];

    // Abort freezes the pipeline for its cycle so the shown output is never accepted.
    assign advance  = busy && !abort && (!out_valid || out_ready);
    assign transfer = advance && out_valid;
    assign issue    = advance && in_run;
    assign flush    = busy && abort;

    assign mbnumber = in_run ? issue_cnt[MB_NUMBER_BITS:0] : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (abort)                               state_d = IDLE;
                else if (issue && issue_cnt == LAST_MB)  state_d = DRAIN;
            end
            DRAIN: begin
                if (abort)                                  state_d = IDLE;
                else if (transfer && retire_cnt == LAST_MB) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            issue_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (((state_q == IDLE) && start) || flush) begin
                issue_cnt  <= '0;
                retire_cnt <= '0;
            end else begin
                if (issue)    issue_cnt  <= issue_cnt + CNT_W'(1);
                if (transfer) retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    intrapred_tag_pipe #(
        .DEPTH (PIPE_DEPTH),
        .TAG_W (MB_NUMBER_BITS + 1)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .advance  (advance),
        .flush    (flush),
        .in_valid (in_run),
        .in_tag   (issue_cnt[MB_NUMBER_BITS:0]),
        .valid    (stage_valid),
        .last_tag (out_mbnumber)
    );

endmodule

// File: tb/tb_intrapred_mb_scheduler.sv
// Bench for intrapred_mb_scheduler: two instances (8 and 2 macroblocks) checked against an advance-count model.
`timescale 1ns/1ps
module tb_intrapred_mb_scheduler;

    localparam int D  = 5;
    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start      [NI];
    logic        abort      [NI];
    logic        out_ready  [NI];
    logic        advance    [NI];
    logic        out_valid  [NI];
    logic        busy       [NI];
    logic        frame_done [NI];
    logic [12:0] mbnumber     [NI];
    logic [12:0] out_mbnumber [NI];
    logic [4:0]  stage_valid  [NI];

    intrapred_mb_scheduler #(.MB_NUMBER_BITS(12), .NUM_MBS(8), .PIPE_DEPTH(5)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
        .advance(advance[0]), .mbnumber(mbnumber[0]), .stage_valid(stage_valid[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_mbnumber(out_mbnumber[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    intrapred_mb_scheduler #(.MB_NUMBER_BITS(12), .NUM_MBS(2), .PIPE_DEPTH(5)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
        .advance(advance[1]), .mbnumber(mbnumber[1]), .stage_valid(stage_valid[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_mbnumber(out_mbnumber[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model: phase 0=idle 1=active 2=done; mk = advances since start.
    // After mk advances, stage s holds macroblock mk-1-s when that lies in 0..N-1.
    int mph [NI];
    int mk  [NI];
    int nph [NI];
    int nk  [NI];
    bit rst_seen = 1'b1;

    int start_cyc  [NI];
    int issue_cyc  [NI][16];
    int retire_cyc [NI][16];
    int done_cyc   [NI];
    int xfer_cnt   [NI];
    int done_cnt   [NI];
    int max_pop    [NI];

    function automatic int nmb(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] cycle %0d: got %0d, expected %0d", name, inst, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int n, rel, otag, pop;
            bit act, ov, adv;
            logic [4:0] sv;
            n   = nmb(i);
            rel = cyc - start_cyc[i];
            if (reset) begin
                chk("rst_advance", i, advance[i], 0);
                chk("rst_busy", i, busy[i], 0);
                chk("rst_frame_done", i, frame_done[i], 0);
                chk("rst_out_valid", i, out_valid[i], 0);
                chk("rst_stage_valid", i, stage_valid[i], 0);
                chk("rst_mbnumber", i, mbnumber[i], 0);
                chk("rst_out_mbnumber", i, out_mbnumber[i], 0);
                nph[i] = 0;
                nk[i]  = 0;
            end else begin
                act = (mph[i] == 1);
                sv  = '0;
                for (int s = 0; s < D; s++)
                    if (act && (mk[i] - 1 - s) >= 0 && (mk[i] - 1 - s) < n) sv[s] = 1'b1;
                ov   = sv[D-1];
                otag = mk[i] - D;
                adv  = act && !abort[i] && (!ov || out_ready[i]);
                chk("stage_valid", i, stage_valid[i], sv);
                chk("out_valid", i, out_valid[i], ov);
                chk("advance", i, advance[i], adv);
                chk("busy", i, busy[i], act);
                chk("frame_done", i, frame_done[i], (mph[i] == 2));
                if (ov) chk("out_mbnumber", i, out_mbnumber[i], otag);
                if (act && mk[i] < n) chk("mbnumber", i, mbnumber[i], mk[i]);

                if (adv && mk[i] < n) issue_cyc[i][mk[i]] = rel;
                if (adv && ov) begin
                    retire_cyc[i][otag] = rel;
                    xfer_cnt[i]++;
                end
                if (mph[i] == 2) begin
                    done_cnt[i]++;
                    done_cyc[i] = rel;
                end
                pop = $countones(stage_valid[i]);
                if (pop > max_pop[i]) max_pop[i] = pop;

                nph[i] = mph[i];
                nk[i]  = mk[i];
                if (act && abort[i]) begin
                    nph[i] = 0;
                end else if (act) begin
                    if (adv) begin
                        if (ov && otag == n - 1) nph[i] = 2;
                        nk[i] = mk[i] + 1;
                    end
                end else if (mph[i] == 2) begin
                    nph[i] = 0;
                end else if (start[i]) begin
                    nph[i] = 1;
                    nk[i]  = 0;
                end
            end
        end
    end

    always @(posedge reset) rst_seen = 1'b1;

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset || rst_seen) begin
                mph[i] = 0;
                mk[i]  = 0;
            end else begin
                mph[i] = nph[i];
                mk[i]  = nk[i];
            end
        end
        rst_seen = 1'b0;
    end

    task automatic clear_log(input int i);
        start_cyc[i] = cyc;
        done_cyc[i]  = -1;
        xfer_cnt[i]  = 0;
        done_cnt[i]  = 0;
        max_pop[i]   = 0;
        for (int m = 0; m < 16; m++) begin
            issue_cyc[i][m]  = -1;
            retire_cyc[i][m] = -1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit s0, input bit s1);
        if (s0) begin clear_log(0); start[0] = 1'b1; end
        if (s1) begin clear_log(1); start[1] = 1'b1; end
        step();
        start[0] = 1'b0;
        start[1] = 1'b0;
    endtask

    task automatic wait_rel(input int i, input int r);
        while (cyc - start_cyc[i] < r) step();
    endtask

    task automatic wait_done(input int i, input int budget);
        int c;
        c = 0;
        while (done_cnt[i] == 0 && c < budget) begin
            step();
            c++;
        end
        if (done_cnt[i] == 0) chk("frame_timeout", i, 0, 1);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; out_ready[i] = 1'b1;
            clear_log(i);
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_reset_busy", 0, busy[0], 0);
        chk("lit_reset_sv", 0, stage_valid[0], 0);
        #2 reset = 1'b0;
        repeat (2) step();

        // Nominal frames on both instances.
        pulse_start(1'b1, 1'b1);
        wait_done(0, 40);
        for (int m = 0; m < 8; m++) begin
            chk("lit_issue_cyc", 0, issue_cyc[0][m], m + 1);
            chk("lit_retire_cyc", 0, retire_cyc[0][m], m + 6);
        end
        chk("lit_done_cyc", 0, done_cyc[0], 14);
        chk("lit_xfers", 0, xfer_cnt[0], 8);
        chk("lit_done_cyc", 1, done_cyc[1], 8);
        chk("lit_retire0", 1, retire_cyc[1][0], 6);
        chk("lit_retire1", 1, retire_cyc[1][1], 7);
        chk("lit_max_pop", 1, max_pop[1], 2);
        chk("lit_xfers", 1, xfer_cnt[1], 2);
        chk("lit_done_cnt", 1, done_cnt[1], 1);

        // Backpressure for cycles 7..9.
        pulse_start(1'b1, 1'b0);
        wait_rel(0, 7);
        out_ready[0] = 1'b0;
        step();
        chk("lit_stall_tag", 0, out_mbnumber[0], 1);
        chk("lit_stall_adv", 0, advance[0], 0);
        chk("lit_stall_sv", 0, stage_valid[0], 5'b11111);
        wait_rel(0, 10);
        out_ready[0] = 1'b1;
        wait_done(0, 40);
        chk("lit_stall_r0", 0, retire_cyc[0][0], 6);
        chk("lit_stall_r1", 0, retire_cyc[0][1], 10);
        chk("lit_stall_r7", 0, retire_cyc[0][7], 16);
        chk("lit_stall_done", 0, done_cyc[0], 17);
        chk("lit_stall_xfers", 0, xfer_cnt[0], 8);

        // start during RUN is ignored.
        pulse_start(1'b1, 1'b0);
        wait_rel(0, 4);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_done(0, 40);
        repeat (5) step();
        chk("lit_restart_xfers", 0, xfer_cnt[0], 8);
        chk("lit_restart_done_cnt", 0, done_cnt[0], 1);
        chk("lit_restart_done", 0, done_cyc[0], 14);

        // Abort with a pending output that downstream would accept.
        pulse_start(1'b1, 1'b0);
        wait_rel(0, 7);
        chk("lit_abort_ov", 0, out_valid[0], 1);
        abort[0] = 1'b1;
        #1;
        chk("lit_abort_adv", 0, advance[0], 0);
        step();
        abort[0] = 1'b0;
        chk("lit_abort_busy", 0, busy[0], 0);
        chk("lit_abort_sv", 0, stage_valid[0], 0);
        repeat (5) step();
        chk("lit_abort_xfers", 0, xfer_cnt[0], 1);
        chk("lit_abort_done_cnt", 0, done_cnt[0], 0);
        pulse_start(1'b1, 1'b0);
        wait_done(0, 40);
        chk("lit_after_abort_issue0", 0, issue_cyc[0][0], 1);
        chk("lit_after_abort_xfers", 0, xfer_cnt[0], 8);

        // Asynchronous reset in the middle of DRAIN.
        pulse_start(1'b1, 1'b0);
        wait_rel(0, 11);
        #2 reset = 1'b1;
        #1;
        chk("lit_async_busy", 0, busy[0], 0);
        chk("lit_async_sv", 0, stage_valid[0], 0);
        chk("lit_async_ov", 0, out_valid[0], 0);
        chk("lit_async_adv", 0, advance[0], 0);
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (5) step();
        chk("lit_post_reset_busy", 0, busy[0], 0);
        pulse_start(1'b1, 1'b0);
        wait_done(0, 40);
        chk("lit_post_reset_done", 0, done_cyc[0], 14);

        // Randomized traffic: backpressure, aborts and start pulses on both instances.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NI; i++) begin
                out_ready[i] = ($urandom_range(0, 3) != 0);
                abort[i]     = ($urandom_range(0, 99) == 0);
                start[i]     = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        for (int i = 0; i < NI; i++) begin
            out_ready[i] = 1'b1; abort[i] = 1'b0; start[i] = 1'b0;
        end
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
